stack_reverser: RTL

//  Stream-side master for the 8x4 LIFO stack: drives Push/Pop/Data_In and consumes Data_Out/Full.

---
 rtl/stack_reverser_pkg.sv | 16 +
 rtl/stack_reverser_if.sv | 22 ++
 rtl/stack_reverser.sv | 129 ++++++++++++
 3 files changed

// File: rtl/stack_reverser_pkg.sv
// Shared state encoding and default sizing for the stack reverser.
package stack_reverser_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int DEPTH_DEF  = 8;
  localparam int CNT_W_DEF  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_POP,
    ST_WAIT,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/stack_reverser_if.sv
// Input and output word streams of the stack reverser (valid/ready on both sides).
interface stack_reverser_if #(parameter int DATA_W = 4) ();
  logic [DATA_W-1:0] In_Data;
  logic              In_Valid;
  logic              In_Last;
  logic              In_Ready;
  logic [DATA_W-1:0] Out_Data;
  logic              Out_Valid;
  logic              Out_Last;
  logic              Out_Ready;

  // master: word source and sink around the reverser
  modport master (
    output In_Data, In_Valid, In_Last, Out_Ready,
    input  In_Ready, Out_Data, Out_Valid, Out_Last
  );

  modport slave (
    input  In_Data, In_Valid, In_Last, Out_Ready,
    output In_Ready, Out_Data, Out_Valid, Out_Last
  );
endinterface

// File: rtl/stack_reverser.sv
// Pushes an input frame into the external LIFO stack, then pops it out reversed.
// Optional STACK_REV_CHECK_EN adds a sticky Err output cross-checking Stk_Full against the count.
//
// state | meaning
// IDLE  | one-cycle gap between frames, Done pulses here
// FILL  | accepting words and pushing them
// POP   | single-cycle stack pop
// WAIT  | stack read data arrives, captured into output register
// HOLD  | output word presented until sink takes it
module stack_reverser
  import stack_reverser_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  stack_reverser_if.slave   Strm,
  output logic              Done,
  output logic              Trunc,
  output logic              Stk_Push,
  output logic              Stk_Pop,
  output logic [DATA_W-1:0] Stk_Wdata,
  input  logic [DATA_W-1:0] Stk_Rdata,
  input  logic              Stk_Full
`ifdef STACK_REV_CHECK_EN
  ,
  output logic              Err
`endif
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              in_ready;
  logic              accept;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              done_q;
  logic              trunc_q;
  logic              stk_pop_q;

  assign in_ready  = (state == ST_FILL) && (cnt < DEPTH_C) && !Stk_Full;
  assign accept    = Strm.In_Valid && in_ready;
  assign Stk_Push  = accept;
  assign Stk_Wdata = Strm.In_Data;

  assign Strm.In_Ready  = in_ready;
  assign Strm.Out_Data  = out_data_q;
  assign Strm.Out_Valid = out_valid_q;
  assign Strm.Out_Last  = out_last_q;
  assign Done           = done_q;
  assign Trunc          = trunc_q;
  assign Stk_Pop        = stk_pop_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      trunc_q     <= 1'b0;
      stk_pop_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      trunc_q   <= 1'b0;
      stk_pop_q <= 1'b0;
      case (state)
        ST_IDLE: state <= ST_FILL;
        ST_FILL: begin
          if (accept) begin
            cnt <= cnt + CNT_W'(1);
            // A frame that fills the stack is drained as-is; In_Last on that word is not a truncation
            if (Strm.In_Last) begin
              state     <= ST_POP;
              stk_pop_q <= 1'b1;
            end else if (cnt == DEPTH_C - CNT_W'(1)) begin
              state     <= ST_POP;
              stk_pop_q <= 1'b1;
              trunc_q   <= 1'b1;
            end
          end
        end
        ST_POP: begin
          cnt   <= cnt - CNT_W'(1);
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          out_data_q  <= Stk_Rdata;
          out_valid_q <= 1'b1;
          out_last_q  <= (cnt == '0);
          state       <= ST_HOLD;
        end
        ST_HOLD: begin
          if (Strm.Out_Ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (cnt != '0) begin
              state     <= ST_POP;
              stk_pop_q <= 1'b1;
            end else begin
              state  <= ST_IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef STACK_REV_CHECK_EN
  // Stack occupancy lags the pop by a cycle, so POP/WAIT are excluded from the compare
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Err <= 1'b0;
    end else if ((state != ST_POP) && (state != ST_WAIT) &&
                 ((Stk_Full && (cnt < DEPTH_C)) || (!Stk_Full && (cnt == DEPTH_C)))) begin
      Err <= 1'b1;
    end
  end
`endif

endmodule
